// File: rtl/ble_pkg.sv
// Shared constants and state types for the BLE power-authorization front end.
package ble_pkg;
  localparam int BAUD_DIV_DEF = 5208;

  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_S = 8'h53;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;
endpackage

// File: rtl/ble_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, framing check.
module ble_uart_rx
  import ble_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frame_err
);
  localparam int          HALF_DIV = BAUD_DIV / 2;
  localparam logic [15:0] HALF_LD  = 16'(HALF_DIV - 1);
  localparam logic [15:0] FULL_LD  = 16'(BAUD_DIV - 1);

  if (BAUD_DIV < 16 || BAUD_DIV > 65535) begin : g_bad_div
    $error("ble_uart_rx: BAUD_DIV out of range 16..65535");
  end

  rx_state_t   state;
  logic        rx_meta, rx_sync, rx_prev;
  logic [15:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic        fall, cnt_zero;

  // Edge detection only ever looks at the synchronized copy of RX.
  assign fall     = rx_prev & ~rx_sync;
  assign cnt_zero = (baud_cnt == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= IDLE;
      baud_cnt  <= 16'd0;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
      rx_data   <= 8'h00;
      rx_rdy    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= RX;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      rx_rdy    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            baud_cnt <= HALF_LD;
            state    <= START;
          end
        end
        START: begin
          if (!cnt_zero) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else if (rx_sync) begin
            state <= IDLE;
          end else begin
            baud_cnt <= FULL_LD;
            bit_cnt  <= 4'd0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (!cnt_zero) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else begin
            shift    <= {rx_sync, shift[7:1]};
            baud_cnt <= FULL_LD;
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) state <= STOP;
          end
        end
        STOP: begin
          if (!cnt_zero) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else begin
            // Returning to IDLE right away lets a back-to-back start bit be caught.
            state <= IDLE;
            if (rx_sync) begin
              rx_data <= shift;
              rx_rdy  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ble_auth_rx.sv
// BLE command receiver plus power-authorization FSM driving the balance enable.
module ble_auth_rx
  import ble_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frame_err,
  output logic       pwr_up
);
  auth_state_t state;
  logic        is_g, is_s;

  ble_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .frame_err (frame_err)
  );

  assign is_g = rx_rdy && (rx_data == CMD_G);
  assign is_s = rx_rdy && (rx_data == CMD_S);

  // pwr_up is registered alongside the state so it tracks (state != OFF) with no extra lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= OFF;
      pwr_up <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          if (is_g) begin
            state  <= PWR1;
            pwr_up <= 1'b1;
          end
        end
        PWR1: begin
          if (is_s) begin
            state  <= rider_off ? OFF : PWR2;
            pwr_up <= ~rider_off;
          end
        end
        PWR2: begin
          // A fresh 'G' outranks the rider stepping off in the same cycle.
          if (is_g) begin
            state <= PWR1;
          end else if (rider_off) begin
            state  <= OFF;
            pwr_up <= 1'b0;
          end
        end
        default: begin
          state  <= OFF;
          pwr_up <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/ble_auth_rx.md
Name: ble_auth_rx

Overview:
- Front end of the Segway power-authorization path. Consumes the 8N1 serial byte stream from the BLE module (RX pin), deserializes it, and decodes the 'G' and 'S' commands.
- Combines decoded commands with the rider-off indication from the load-cell logic to produce the registered pwr_up enable for the balance controller.
- Sits directly downstream of the BLE UART transmitter and upstream of the balance/PWM enable logic.

Parameters:
- BAUD_DIV, 5208, clk cycles per bit (50 MHz / 9600 baud); legal range 16..65535.
- HALF_DIV, BAUD_DIV/2, cycles from the start edge to the start-bit mid-sample (derived, not overridable).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-high reset.
- RX  input  1  asynchronous serial input; idles high.
- rider_off  input  1  high when the rider is off the platform; synchronous to clk.
- rx_data  output  8  last correctly framed byte; held until the next one arrives.
- rx_rdy  output  1  single-cycle pulse when rx_data updates.
- frame_err  output  1  single-cycle pulse when the stop bit is sampled low.
- pwr_up  output  1  registered enable to the balance controller.

Behaviour:
- Reset (asynchronous, active-high):
  - RX synchronizer flops preset to 1.
  - rx_data=8'h00, rx_rdy=0, frame_err=0, pwr_up=0.
  - Both FSMs return to their initial states, including when reset arrives mid-frame.
- RX is double-flopped before any use. A falling edge is detected on the synchronized value only.
- RX FSM states:
  - IDLE: on a synchronized falling edge, load baud_cnt=HALF_DIV-1 and go to START.
  - START: at count 0, sample the line.
    - If high (glitch), return to IDLE with no outputs.
    - Otherwise reload baud_cnt=BAUD_DIV-1, clear bit_cnt, go to DATA.
  - DATA: at each count 0, shift the sample in LSB-first and reload.
    - After the 8th bit go to STOP.
  - STOP: at count 0, sample the line and return to IDLE.
    - High: the next cycle loads rx_data and pulses rx_rdy.
    - Low: pulse frame_err only; rx_data is unchanged and no command is decoded.
- Counters: baud_cnt is 16-bit, down-counting, with no wrap in use. bit_cnt is 4-bit.
- Back-to-back frames are accepted. IDLE re-arms in the cycle after the stop sample, so a start bit immediately following is caught.
- Auth FSM state changes are registered. pwr_up = (state != OFF), registered, and valid one cycle after rx_rdy.
  - OFF: rx_rdy with CMD_G → PWR1. Any other byte is ignored.
  - PWR1: rx_rdy with CMD_S:
    - rider_off=1 → OFF.
    - rider_off=0 → PWR2 (stay powered until the rider steps off).
  - PWR2:
    - rx_rdy with CMD_G → PWR1.
    - Else rider_off=1 → OFF.
    - When both occur in the same cycle, CMD_G wins.
- Unknown bytes (anything other than 'G'/'S') never change the auth state.
- Latency: from the stop-bit mid-sample, rx_rdy follows 1 cycle later and pwr_up changes 2 cycles later.

Decomposition:
- Shared package ble_pkg:
  - Command constants CMD_G=8'h47 and CMD_S=8'h53.
  - Enums rx_state_t {IDLE,START,DATA,STOP} and auth_state_t {OFF,PWR1,PWR2}.
  - Default BAUD_DIV constant.
- One sub-module, ble_uart_rx: synchronizer, baud/bit counters and RX FSM, with outputs rx_data/rx_rdy/frame_err.
- The auth FSM lives in ble_auth_rx itself.

Test Plan (bench runs with BAUD_DIV=16 unless noted):
1. Reset, then send 8'h47 with rider_off=0 → rx_data=8'h47 and rx_rdy pulses once. pwr_up rises 2 clks after the stop mid-sample and stays high.
2. pwr_up=1, rider_off=0, send 8'h53 → pwr_up stays 1. Raise rider_off after 100 clks → pwr_up falls 1 clk later.
3. pwr_up=1, rider_off=1, send 8'h53 → pwr_up falls 2 clks after the stop mid-sample. Then send 8'h41 → pwr_up stays 0 and rx_data=8'h41.
4. Frame 8'h47 with a low stop bit → frame_err pulses once, rx_rdy stays 0 and pwr_up stays 0. Separately, a 3-clk low glitch on RX → no rx_rdy and no frame_err.
5. Back-to-back 8'h47 then 8'h53 (no idle gap) with rider_off=0 → exactly two rx_rdy pulses, state ends in PWR2 and pwr_up=1. Then send 8'h47 with rider_off=1 in the same cycle as rx_rdy → state PWR1 and pwr_up=1.
6. Assert rst during the 4th data bit of 8'h47 → all outputs 0 immediately (asynchronous). After release, a full 8'h47 frame is received correctly. Repeat at BAUD_DIV=5208 with the system UART_tx driving RX.
